// File: rtl/baseline_track.sv
// Four independent per-channel baseline estimators: average 2^LOG2_N enabled samples
// and commit the mean only when the window was quiet (small spread, no alarm).
module baseline_track #(
  parameter int          LOG2_N    = 4,
  parameter logic [15:0] STABLE_TH = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Ch0_Data,
  input  logic [15:0] Ch1_Data,
  input  logic [15:0] Ch2_Data,
  input  logic [15:0] Ch3_Data,
  input  logic        Ch0_Data_en,
  input  logic        Ch1_Data_en,
  input  logic        Ch2_Data_en,
  input  logic        Ch3_Data_en,
  input  logic        Ch0_alarm,
  input  logic        Ch1_alarm,
  input  logic        Ch2_alarm,
  input  logic        Ch3_alarm,
  output logic [15:0] Ch0_baseline,
  output logic [15:0] Ch1_baseline,
  output logic [15:0] Ch2_baseline,
  output logic [15:0] Ch3_baseline,
  output logic        Ch0_baseline_valid,
  output logic        Ch1_baseline_valid,
  output logic        Ch2_baseline_valid,
  output logic        Ch3_baseline_valid,
  output logic        Ch0_baseline_upd,
  output logic        Ch1_baseline_upd,
  output logic        Ch2_baseline_upd,
  output logic        Ch3_baseline_upd
);

  localparam int                ACC_W    = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  logic [15:0] data     [4];
  logic        data_en  [4];
  logic        alarm    [4];
  logic [15:0] base_out [4];
  logic        vld_out  [4];
  logic        upd_out  [4];

  assign data[0] = Ch0_Data;
  assign data[1] = Ch1_Data;
  assign data[2] = Ch2_Data;
  assign data[3] = Ch3_Data;
  assign data_en[0] = Ch0_Data_en;
  assign data_en[1] = Ch1_Data_en;
  assign data_en[2] = Ch2_Data_en;
  assign data_en[3] = Ch3_Data_en;
  assign alarm[0] = Ch0_alarm;
  assign alarm[1] = Ch1_alarm;
  assign alarm[2] = Ch2_alarm;
  assign alarm[3] = Ch3_alarm;

  assign Ch0_baseline = base_out[0];
  assign Ch1_baseline = base_out[1];
  assign Ch2_baseline = base_out[2];
  assign Ch3_baseline = base_out[3];
  assign Ch0_baseline_valid = vld_out[0];
  assign Ch1_baseline_valid = vld_out[1];
  assign Ch2_baseline_valid = vld_out[2];
  assign Ch3_baseline_valid = vld_out[3];
  assign Ch0_baseline_upd = upd_out[0];
  assign Ch1_baseline_upd = upd_out[1];
  assign Ch2_baseline_upd = upd_out[2];
  assign Ch3_baseline_upd = upd_out[3];

  // Mean including the closing sample; the accumulator is wide enough that the sum never wraps.
  function automatic logic [15:0] win_mean(input logic [ACC_W-1:0] acc, input logic [15:0] d);
    logic [ACC_W-1:0] sum;
    sum = acc + ACC_W'(d);
    return 16'(sum >> LOG2_N);
  endfunction

  function automatic logic [15:0] win_spread(input logic [15:0] hi_q, input logic [15:0] lo_q,
                                              input logic [15:0] d);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = (d > hi_q) ? d : hi_q;
    lo = (d < lo_q) ? d : lo_q;
    return hi - lo;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_ch
    state_t            state_q, state_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [15:0]       wmax_q, wmax_d;
    logic [15:0]       wmin_q, wmin_d;
    logic              taint_q, taint_d;
    logic [15:0]       base_q, base_d;
    logic              valid_q, valid_d;
    logic              upd_q, upd_d;
    logic              win_open;
    logic              quiet;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
        wmax_q  <= '0;
        wmin_q  <= '0;
        taint_q <= 1'b0;
        base_q  <= '0;
        valid_q <= 1'b0;
        upd_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        wmax_q  <= wmax_d;
        wmin_q  <= wmin_d;
        taint_q <= taint_d;
        base_q  <= base_d;
        valid_q <= valid_d;
        upd_q   <= upd_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      wmax_d   = wmax_q;
      wmin_d   = wmin_q;
      taint_d  = taint_q;
      base_d   = base_q;
      valid_d  = valid_q;
      upd_d    = 1'b0;
      // A window is open only in ACCUM between its first and last sample.
      win_open = (state_q == S_ACCUM) && (cnt_q != '0);
      quiet    = !taint_q && !alarm[c] &&
                 (win_spread(wmax_q, wmin_q, data[c]) <= STABLE_TH);

      if (data_en[c]) begin
        if (!win_open) begin
          state_d = S_ACCUM;
          acc_d   = ACC_W'(data[c]);
          wmax_d  = data[c];
          wmin_d  = data[c];
          cnt_d   = CNT_ONE;
          taint_d = alarm[c];
        end else if (cnt_q == CNT_LAST) begin
          if (quiet) begin
            base_d  = win_mean(acc_q, data[c]);
            valid_d = 1'b1;
            upd_d   = 1'b1;
          end
          cnt_d   = '0;
          taint_d = 1'b0;
        end else begin
          acc_d   = acc_q + ACC_W'(data[c]);
          wmax_d  = (data[c] > wmax_q) ? data[c] : wmax_q;
          wmin_d  = (data[c] < wmin_q) ? data[c] : wmin_q;
          cnt_d   = cnt_q + CNT_ONE;
          taint_d = taint_q | alarm[c];
        end
      end else if (win_open && alarm[c]) begin
        taint_d = 1'b1;
      end
    end

    assign base_out[c] = base_q;
    assign vld_out[c]  = valid_q;
    assign upd_out[c]  = upd_q;
  end

endmodule

// File: tb/tb_baseline_track.sv
// Directed bench for baseline_track: a queue-based window model checked every cycle,
// plus literal expectations for each scenario.
module tb_baseline_track;
  localparam int L  = 4;
  localparam int N  = 16;
  localparam int TH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d  [4];
  logic        en [4];
  logic        al [4];
  logic [15:0] bl [4];
  logic        bv [4];
  logic        bu [4];

  always #5 clk = ~clk;

  baseline_track #(.LOG2_N(L), .STABLE_TH(16'(TH))) dut (
    .clk(clk), .rst(rst),
    .Ch0_Data(d[0]), .Ch1_Data(d[1]), .Ch2_Data(d[2]), .Ch3_Data(d[3]),
    .Ch0_Data_en(en[0]), .Ch1_Data_en(en[1]), .Ch2_Data_en(en[2]), .Ch3_Data_en(en[3]),
    .Ch0_alarm(al[0]), .Ch1_alarm(al[1]), .Ch2_alarm(al[2]), .Ch3_alarm(al[3]),
    .Ch0_baseline(bl[0]), .Ch1_baseline(bl[1]), .Ch2_baseline(bl[2]), .Ch3_baseline(bl[3]),
    .Ch0_baseline_valid(bv[0]), .Ch1_baseline_valid(bv[1]),
    .Ch2_baseline_valid(bv[2]), .Ch3_baseline_valid(bv[3]),
    .Ch0_baseline_upd(bu[0]), .Ch1_baseline_upd(bu[1]),
    .Ch2_baseline_upd(bu[2]), .Ch3_baseline_upd(bu[3])
  );

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 0;
  logic [15:0] win [4][$];
  bit          tnt [4];
  logic [15:0] e_base [4];
  bit          e_val [4];
  bit          e_upd [4];
  int          m_upd_n [4];
  int          d_upd_n [4];

  initial begin
    for (int c = 0; c < 4; c++) begin
      e_base[c] = '0; e_val[c] = 0; e_upd[c] = 0; tnt[c] = 0;
      m_upd_n[c] = 0; d_upd_n[c] = 0;
      d[c] = '0; en[c] = 0; al[c] = 0;
    end
  end

  task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0d, expected %0d", nm, c, got, exp);
    end
  endtask

  // Window model: collect the samples of the open window, decide when N are present.
  task automatic model_step();
    longint sum;
    int     mx, mn;
    for (int c = 0; c < 4; c++) begin
      e_upd[c] = 0;
      if (rst) begin
        win[c].delete(); tnt[c] = 0; e_base[c] = '0; e_val[c] = 0;
      end else if (en[c]) begin
        tnt[c] = tnt[c] | al[c];
        win[c].push_back(d[c]);
        if (win[c].size() == N) begin
          sum = 0; mx = 0; mn = 65535;
          foreach (win[c][i]) begin
            sum += win[c][i];
            if (int'(win[c][i]) > mx) mx = win[c][i];
            if (int'(win[c][i]) < mn) mn = win[c][i];
          end
          if (!tnt[c] && (mx - mn) <= TH) begin
            e_base[c] = 16'(sum / N); e_val[c] = 1; e_upd[c] = 1; m_upd_n[c]++;
          end
          win[c].delete(); tnt[c] = 0;
        end
      end else if (al[c] && win[c].size() > 0) begin
        tnt[c] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < 4; c++) begin
        check("baseline", c, bl[c], e_base[c]);
        check("valid", c, bv[c], e_val[c]);
        check("upd", c, bu[c], e_upd[c]);
        if (bu[c] === 1'b1) d_upd_n[c]++;
      end
    end
  end

  task automatic clr();
    for (int c = 0; c < 4; c++) begin en[c] = 0; al[c] = 0; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input int c, input logic [15:0] v, input bit a);
    clr();
    d[c] = v; en[c] = 1; al[c] = a;
    tick();
    clr();
  endtask

  task automatic lit(input string nm, input int c, input logic [15:0] b, input bit v, input bit u);
    check({nm, "_base"}, c, bl[c], b);
    check({nm, "_valid"}, c, bv[c], v);
    check({nm, "_upd"}, c, bu[c], u);
    check({nm, "_model"}, c, e_base[c], b);
  endtask

  initial begin
    rst = 1; clr();
    repeat (3) tick();
    chk_on = 1;
    for (int c = 0; c < 4; c++) lit("reset", c, 16'd0, 0, 0);
    rst = 0;
    tick();

    // Ch0: constant window
    for (int i = 0; i < N; i++) feed(0, 16'd1000, 0);
    lit("ch0_const", 0, 16'd1000, 1, 1);
    lit("ch0_other", 1, 16'd0, 0, 0);
    tick();
    check("ch0_upd_width", 0, bu[0], 0);

    // Ch1: ramp with enable gaps, truncating mean
    for (int i = 0; i < N; i++) begin
      feed(1, 16'(1000 + i), 0);
      if (i == N - 1) lit("ch1_ramp", 1, 16'd1007, 1, 1);
      if (i % 3 == 0) tick();
    end
    tick();

    // Ch2: spread 100 rejected, spread exactly 64 commits
    for (int i = 0; i < N - 1; i++) feed(2, 16'd1000, 0);
    feed(2, 16'd1100, 0);
    lit("ch2_reject", 2, 16'd0, 0, 0);
    for (int i = 0; i < N - 1; i++) feed(2, 16'd1000, 0);
    feed(2, 16'd1064, 0);
    lit("ch2_edge", 2, 16'd1004, 1, 1);
    tick();

    // Ch3: alarm without enable mid-window, alarm on the last sample, alarm after close
    for (int i = 0; i < 8; i++) feed(3, 16'd3000, 0);
    clr(); al[3] = 1; tick(); clr();
    for (int i = 0; i < 8; i++) feed(3, 16'd3000, 0);
    lit("ch3_alarm_gap", 3, 16'd0, 0, 0);
    for (int i = 0; i < N - 1; i++) feed(3, 16'd3000, 0);
    feed(3, 16'd3000, 1);
    lit("ch3_alarm_last", 3, 16'd0, 0, 0);
    clr(); al[3] = 1; tick(); clr();
    for (int i = 0; i < N; i++) feed(3, 16'd3000, 0);
    lit("ch3_clean", 3, 16'd3000, 1, 1);
    tick();

    // All channels in parallel
    for (int i = 0; i < N; i++) begin
      clr();
      d[0] = 16'd0; d[1] = 16'd500; d[2] = 16'd30000; d[3] = 16'hFFFF;
      for (int c = 0; c < 4; c++) en[c] = 1;
      tick();
    end
    clr();
    lit("par", 0, 16'd0, 1, 1);
    lit("par", 1, 16'd500, 1, 1);
    lit("par", 2, 16'd30000, 1, 1);
    lit("par", 3, 16'hFFFF, 1, 1);
    tick();

    // Reset mid-window, with a sample in the reset cycle
    for (int i = 0; i < N; i++) feed(0, 16'd1000, 0);
    lit("ch0_again", 0, 16'd1000, 1, 1);
    for (int i = 0; i < 10; i++) feed(0, 16'd2000, 0);
    rst = 1; d[0] = 16'd2000; en[0] = 1;
    tick();
    rst = 0; clr();
    lit("rst_mid", 0, 16'd0, 0, 0);
    lit("rst_mid", 3, 16'd0, 0, 0);
    for (int i = 1; i <= N; i++) begin
      feed(0, 16'd2000, 0);
      if (i == 6) lit("rst_leftover", 0, 16'd0, 0, 0);
    end
    lit("rst_after", 0, 16'd2000, 1, 1);
    tick(); tick();

    check("upd_count_dut", 0, d_upd_n[0], 4);
    check("upd_count_dut", 1, d_upd_n[1], 2);
    check("upd_count_dut", 2, d_upd_n[2], 2);
    check("upd_count_dut", 3, d_upd_n[3], 2);
    check("upd_count_model", 0, m_upd_n[0], 4);
    check("upd_count_model", 3, m_upd_n[3], 2);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
